// File: rtl/timer_pkg.sv
// Shared constants and channel state layout for the interrupt timer bank.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package timer_pkg;

    localparam logic TMR_MODE_ONESHOT  = 1'b0;
    localparam logic TMR_MODE_PERIODIC = 1'b1;

    localparam int          TMR_WIDTH      = 32;
    localparam logic [31:0] TMR_RESET_LOAD = 32'hefffffff;

    // Layout of one channel at the default width.
    typedef struct packed {
        logic [TMR_WIDTH-1:0] count;
        logic [TMR_WIDTH-1:0] reload;
        logic                 running;
        logic                 mode;
        logic                 pending;
    } tmr_chan_t;

endpackage

// File: rtl/timer_bank_if.sv
// Control/status bundle between the fetch-stage interrupt logic and the timer bank.
// Latency: n/a (wires only).
// Backpressure: none; commands are single-cycle pulses, always accepted.
interface timer_bank_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32
);
    localparam int CHW = $clog2(NCH);

    logic             load_en;
    logic             dis_en;
    logic [CHW-1:0]   sel;
    logic [WIDTH-1:0] load_val;
    logic             periodic;
    logic             ack;
    logic [CHW-1:0]   ack_ch;
    logic [NCH-1:0]   mask;
    logic [NCH-1:0]   pending;
    logic             irq;
    logic [CHW-1:0]   irq_ch;
    logic [WIDTH-1:0] count_val;

    modport master (
        output load_en, dis_en, sel, load_val, periodic, ack, ack_ch, mask,
        input  pending, irq, irq_ch, count_val
    );

    modport slave (
        input  load_en, dis_en, sel, load_val, periodic, ack, ack_ch, mask,
        output pending, irq, irq_ch, count_val
    );

endinterface

// File: rtl/timer_channel.sv
// One down-counting timer channel: count/reload registers, mode and sticky pending flag.
// Latency: pending sets on the edge after the count reaches zero.
// Backpressure: none; ld/dis/clr are accepted every cycle.
module timer_channel
    import timer_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ld,
    input  logic             dis,
    input  logic             clr,
    input  logic [WIDTH-1:0] load_val,
    input  logic             periodic,
    output logic             pending,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             running_q;
    logic             mode_q;
    logic             pending_q;

    // Precedence: disarm > load > expiry > decrement; an expiry beats a same-cycle ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= RST_VAL;
            reload_q  <= RST_VAL;
            running_q <= 1'b0;
            mode_q    <= TMR_MODE_ONESHOT;
            pending_q <= 1'b0;
        end else if (dis) begin
            running_q <= 1'b0;
            pending_q <= 1'b0;
        end else if (ld) begin
            count_q   <= load_val;
            reload_q  <= load_val;
            mode_q    <= periodic;
            running_q <= (load_val != '0);
            if (clr) pending_q <= 1'b0;
        end else if (running_q && count_q == '0) begin
            pending_q <= 1'b1;
            if (mode_q == TMR_MODE_PERIODIC) count_q   <= reload_q;
            else                             running_q <= 1'b0;
        end else begin
            if (running_q) count_q <= count_q - 1'b1;
            if (clr)       pending_q <= 1'b0;
        end
    end

    assign pending = pending_q;
    assign count   = count_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of NCH interrupt timers with mask, fixed-priority irq encode and count readback.
// Latency: commands take effect on the next edge; irq/irq_ch/count_val are combinational.
// Backpressure: none; every command is accepted in the cycle it is presented.
module timer_bank
    import timer_pkg::*;
#(
    parameter int          NCH        = 4,
    parameter int          WIDTH      = 32,
    parameter logic [31:0] RESET_LOAD = TMR_RESET_LOAD
) (
    input  logic         clk,
    input  logic         reset_n,
    timer_bank_if.slave  bus
);

    localparam int CHW = $clog2(NCH);

    logic [NCH-1:0]   ld;
    logic [NCH-1:0]   dis;
    logic [NCH-1:0]   clr;
    logic [NCH-1:0]   pend;
    logic [WIDTH-1:0] cnt [NCH];
    logic [CHW-1:0]   irq_ch;
    logic [WIDTH-1:0] count_val;

    // Out-of-range sel/ack_ch values match no channel, so those commands drop out here.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign ld[g]  = bus.load_en && (bus.sel    == CHW'(g));
        assign dis[g] = bus.dis_en  && (bus.sel    == CHW'(g));
        assign clr[g] = bus.ack     && (bus.ack_ch == CHW'(g));

        timer_channel #(
            .WIDTH   (WIDTH),
            .RST_VAL (WIDTH'(RESET_LOAD))
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .ld       (ld[g]),
            .dis      (dis[g]),
            .clr      (clr[g]),
            .load_val (bus.load_val),
            .periodic (bus.periodic),
            .pending  (pend[g]),
            .count    (cnt[g])
        );
    end

    always_comb begin
        irq_ch    = '0;
        count_val = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend[i] && bus.mask[i]) irq_ch = CHW'(i);
        end
        for (int i = 0; i < NCH; i++) begin
            if (bus.sel == CHW'(i)) count_val = cnt[i];
        end
    end

    assign bus.pending   = pend;
    assign bus.irq       = |(pend & bus.mask);
    assign bus.irq_ch    = irq_ch;
    assign bus.count_val = count_val;

endmodule
